fft_serial_n: RTL and testbench

- Parametrised successor to the fixed 8-point single-bit FFT block.
- Sequential in-place radix-2 decimation-in-time FFT over N = 2^LOG2N complex samples, using one time-shared butterfly.
- Samples stream in under enable `e`. The transform runs automatically once the frame is full.
- Results are read back through a random-access select port `s` instead of N parallel output wires.

---
 rtl/fft_serial_n.sv | 198 +++++++++++++++++++
 tb/tb_fft_serial_n.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_serial_n.sv
// fft_serial_n: sequential in-place radix-2 DIT FFT over N = 2^LOG2N complex samples.
// A single butterfly is reused for every stage, one butterfly per cycle.
//
// Ports:
//   c          clock, rising edge
//   r          asynchronous active-high reset
//   e          sample enable; one sample accepted per cycle while high (idle/load/done)
//   x_re/x_im  signed W-bit input sample
//   s          result bin select, natural order
//   y_re/y_im  signed (W+LOG2N)-bit bin s, registered; 0 outside the done state
//   busy       high while the transform is computing
//   done       high while a valid result frame is held
module fft_serial_n #(
   parameter int unsigned LOG2N = 3,
   parameter int unsigned W     = 2,
   parameter int unsigned TW    = 8
) (
   input  logic                           c,
   input  logic                           r,
   input  logic                           e,
   input  logic signed [W-1:0]            x_re,
   input  logic signed [W-1:0]            x_im,
   input  logic        [LOG2N-1:0]        s,
   output logic signed [W+LOG2N-1:0]      y_re,
   output logic signed [W+LOG2N-1:0]      y_im,
   output logic                           busy,
   output logic                           done
);

   localparam int N  = 1 << LOG2N;
   localparam int IW = W + LOG2N;
   localparam int JW = LOG2N - 1;
   localparam int PW = IW + TW + 1;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StLoad = 2'd1;
   localparam logic [1:0] StComp = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

   // Quarter-wave magnitudes cos(2*pi*q/16), q = 0..3, from Q0.16 constants rounded to TW.
   // 1.0 is encoded as the largest positive code.
   localparam int TwOneI  = (1 << (TW - 1)) - 1;
   localparam int TwC1Raw = (60547 + (1 << (16 - TW))) >> (17 - TW);
   localparam int TwC2Raw = (46341 + (1 << (16 - TW))) >> (17 - TW);
   localparam int TwC3Raw = (25080 + (1 << (16 - TW))) >> (17 - TW);
   localparam int TwC1I   = (TwC1Raw > TwOneI) ? TwOneI : TwC1Raw;
   localparam int TwC2I   = (TwC2Raw > TwOneI) ? TwOneI : TwC2Raw;
   localparam int TwC3I   = (TwC3Raw > TwOneI) ? TwOneI : TwC3Raw;
   localparam logic signed [TW-1:0] TwOne = TW'(TwOneI);
   localparam logic signed [TW-1:0] TwC1  = TW'(TwC1I);
   localparam logic signed [TW-1:0] TwC2  = TW'(TwC2I);
   localparam logic signed [TW-1:0] TwC3  = TW'(TwC3I);
   localparam int RndI = 1 << (TW - 2);

   logic [1:0]             state_q, state_d;
   logic [LOG2N-1:0]       k_q, k_d;
   logic [1:0]             m_q, m_d;
   logic [JW-1:0]          j_q, j_d;
   logic signed [IW-1:0]   mem_re_q [N];
   logic signed [IW-1:0]   mem_re_d [N];
   logic signed [IW-1:0]   mem_im_q [N];
   logic signed [IW-1:0]   mem_im_d [N];
   logic signed [IW-1:0]   y_re_q, y_re_d, y_im_q, y_im_d;
   logic                   done_q, done_d;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
      logic [LOG2N-1:0] o;
      for (int i = 0; i < int'(LOG2N); i++) o[i] = v[int'(LOG2N) - 1 - i];
      return o;
   endfunction

   function automatic logic signed [TW-1:0] tw_mag(input logic [2:0] q);
      case (q)
         3'd0:    tw_mag = TwOne;
         3'd1:    tw_mag = TwC1;
         3'd2:    tw_mag = TwC2;
         3'd3:    tw_mag = TwC3;
         default: tw_mag = '0;
      endcase
   endfunction

   // Butterfly datapath
   logic [LOG2N-1:0]      j_ext, span, mask, t_off, addr_a, addr_b;
   logic [2:0]            rom_idx;
   logic signed [TW-1:0]  w_re, w_im, sin_v;
   logic signed [PW-1:0]  br_x, bi_x, wr_x, wi_x, pr_sum, pi_sum;
   logic signed [IW-1:0]  a_re, a_im, p_re, p_im;

   always_comb begin
      j_ext  = LOG2N'(j_q);
      span   = LOG2N'(1) << m_q;
      mask   = span - LOG2N'(1);
      t_off  = j_ext & mask;
      // Insert a zero at bit m of j to get the upper-half-free address a; b sets that bit.
      addr_a = ((j_ext & ~mask) << 1) | t_off;
      addr_b = addr_a | span;
      // Twiddle index t*N/(2h) rescaled to a 16-point circle collapses to t << (3-m).
      rom_idx = 3'(4'(t_off) << (2'd3 - m_q));
      w_re   = (rom_idx <= 3'd4) ? tw_mag(rom_idx) : -tw_mag(3'd0 - rom_idx);
      sin_v  = (rom_idx <= 3'd4) ? tw_mag(3'd4 - rom_idx) : tw_mag(rom_idx - 3'd4);
      w_im   = -sin_v;

      a_re   = mem_re_q[addr_a];
      a_im   = mem_im_q[addr_a];
      br_x   = PW'(mem_re_q[addr_b]);
      bi_x   = PW'(mem_im_q[addr_b]);
      wr_x   = PW'(w_re);
      wi_x   = PW'(w_im);
      pr_sum = br_x * wr_x - bi_x * wi_x + PW'(RndI);
      pi_sum = br_x * wi_x + bi_x * wr_x + PW'(RndI);
      p_re   = IW'(pr_sum >>> (TW - 1));
      p_im   = IW'(pi_sum >>> (TW - 1));
   end

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      m_d      = m_q;
      j_d      = j_q;
      mem_re_d = mem_re_q;
      mem_im_d = mem_im_q;
      done_d   = (state_q == StDone);
      y_re_d   = '0;
      y_im_d   = '0;
      if (state_q == StDone) begin
         y_re_d = mem_re_q[s];
         y_im_d = mem_im_q[s];
      end

      case (state_q)
         StComp: begin
            mem_re_d[addr_a] = a_re + p_re;
            mem_im_d[addr_a] = a_im + p_im;
            mem_re_d[addr_b] = a_re - p_re;
            mem_im_d[addr_b] = a_im - p_im;
            if (j_q == JW'(N / 2 - 1)) begin
               j_d = '0;
               if (m_q == 2'(LOG2N - 1)) begin
                  m_d     = '0;
                  state_d = StDone;
               end else begin
                  m_d = m_q + 2'd1;
               end
            end else begin
               j_d = j_q + JW'(1);
            end
         end
         default: begin
            // Idle, load and done all accept; done starts a new frame over the old one.
            if (e) begin
               mem_re_d[bitrev(k_q)] = IW'(x_re);
               mem_im_d[bitrev(k_q)] = IW'(x_im);
               if (k_q == LOG2N'(N - 1)) begin
                  state_d = StComp;
                  k_d     = '0;
                  m_d     = '0;
                  j_d     = '0;
               end else begin
                  state_d = StLoad;
                  k_d     = k_q + LOG2N'(1);
               end
            end
         end
      endcase
   end

   always_ff @(posedge c or posedge r) begin
      if (r) begin
         state_q <= StIdle;
         k_q     <= '0;
         m_q     <= '0;
         j_q     <= '0;
         y_re_q  <= '0;
         y_im_q  <= '0;
         done_q  <= 1'b0;
         for (int i = 0; i < N; i++) begin
            mem_re_q[i] <= '0;
            mem_im_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         m_q      <= m_d;
         j_q      <= j_d;
         y_re_q   <= y_re_d;
         y_im_q   <= y_im_d;
         done_q   <= done_d;
         mem_re_q <= mem_re_d;
         mem_im_q <= mem_im_d;
      end
   end

   assign y_re = y_re_q;
   assign y_im = y_im_q;
   assign busy = (state_q == StComp);
   assign done = done_q;

endmodule

// File: tb/tb_fft_serial_n.sv
// tb_fft_serial_n: self-checking bench for fft_serial_n with an 8-point (W=2) and a
// 16-point (W=3) instance, compared against a behavioural fixed-point FFT model.
module tb_fft_serial_n;

   logic c = 1'b0;
   logic r;
   always #5 c = ~c;

   logic              e_a, busy_a, done_a;
   logic signed [1:0] xr_a, xi_a;
   logic [2:0]        s_a;
   logic signed [4:0] yr_a, yi_a;
   logic              e_b, busy_b, done_b;
   logic signed [2:0] xr_b, xi_b;
   logic [3:0]        s_b;
   logic signed [6:0] yr_b, yi_b;

   fft_serial_n #(.LOG2N(3), .W(2), .TW(8)) dut_a (
      .c(c), .r(r), .e(e_a), .x_re(xr_a), .x_im(xi_a), .s(s_a),
      .y_re(yr_a), .y_im(yi_a), .busy(busy_a), .done(done_a)
   );

   fft_serial_n #(.LOG2N(4), .W(3), .TW(8)) dut_b (
      .c(c), .r(r), .e(e_b), .x_re(xr_b), .x_im(xi_b), .s(s_b),
      .y_re(yr_b), .y_im(yi_b), .busy(busy_b), .done(done_b)
   );

   int n_checks = 0;
   int n_errors = 0;
   int sel, lg, nn;
   int fr_re [16];
   int fr_im [16];
   int ex_re [16];
   int ex_im [16];
   int got_re [16];
   int got_im [16];

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge c);
      #1;
   endtask

   task automatic use_dut(input int which);
      sel = which;
      lg  = which ? 4 : 3;
      nn  = 1 << lg;
   endtask

   task automatic drive(input logic en, input int xr, input int xi);
      if (sel == 0) begin
         e_a = en; xr_a = 2'(xr); xi_a = 2'(xi);
      end else begin
         e_b = en; xr_b = 3'(xr); xi_b = 3'(xi);
      end
   endtask

   task automatic set_s(input int v);
      if (sel == 0) s_a = 3'(v);
      else s_b = 4'(v);
   endtask

   function automatic int y_re_now();
      return sel ? int'(yr_b) : int'(yr_a);
   endfunction
   function automatic int y_im_now();
      return sel ? int'(yi_b) : int'(yi_a);
   endfunction
   function automatic int busy_now();
      return sel ? int'(busy_b) : int'(busy_a);
   endfunction
   function automatic int done_now();
      return sel ? int'(done_b) : int'(done_a);
   endfunction

   // Small enough that the unscaled transform never leaves the output range.
   function automatic int rnd_sample();
      int lim;
      lim = sel ? 2 : 1;
      return int'($urandom_range(2 * lim)) - lim;
   endfunction

   function automatic int brev(input int v, input int bits);
      int o;
      o = 0;
      for (int i = 0; i < bits; i++) if (v[i]) o = o | (1 << (bits - 1 - i));
      return o;
   endfunction

   // Q1.7 twiddle: round half up, 1.0 saturates to 127.
   function automatic int qtw(input real v);
      int q;
      q = $rtoi($floor(v * 128.0 + 0.5));
      if (q > 127) q = 127;
      if (q < -128) q = -128;
      return q;
   endfunction

   // Radix-2 DIT on a bit-reversed copy of the frame, products rounded to Q0.
   task automatic model();
      int  mr [16];
      int  mi [16];
      int  h, a, b, t, idx, wr, wi, pr, pim, ar, ai;
      real ang;
      for (int k = 0; k < nn; k++) begin
         mr[brev(k, lg)] = fr_re[k];
         mi[brev(k, lg)] = fr_im[k];
      end
      for (int m = 0; m < lg; m++) begin
         h = 1 << m;
         for (int j = 0; j < nn / 2; j++) begin
            t   = j % h;
            a   = (j / h) * 2 * h + t;
            b   = a + h;
            idx = t * (nn / (2 * h));
            ang = 2.0 * 3.14159265358979 * idx / nn;
            wr  = qtw($cos(ang));
            wi  = -qtw($sin(ang));
            pr  = (mr[b] * wr - mi[b] * wi + 64) >>> 7;
            pim = (mr[b] * wi + mi[b] * wr + 64) >>> 7;
            ar  = mr[a];
            ai  = mi[a];
            mr[a] = ar + pr;  mi[a] = ai + pim;
            mr[b] = ar - pr;  mi[b] = ai - pim;
         end
      end
      for (int k = 0; k < nn; k++) begin
         ex_re[k] = mr[k];
         ex_im[k] = mi[k];
      end
   endtask

   task automatic load_frame(input bit gap);
      for (int k = 0; k < nn; k++) begin
         drive(1'b1, fr_re[k], fr_im[k]);
         tick();
         if (gap && k != nn - 1) begin
            drive(1'b0, rnd_sample(), rnd_sample());
            tick();
         end
      end
      drive(1'b0, 0, 0);
      check("done_low_after_load", done_now(), 0);
   endtask

   task automatic finish_frame(input bit pulse);
      int cyc, bcnt;
      cyc  = 0;
      bcnt = 0;
      while (done_now() == 0 && cyc < 200) begin
         if (busy_now() != 0) bcnt++;
         if (cyc == 3) check("y_zero_in_comp", y_re_now(), 0);
         if (pulse && cyc < lg * nn / 2) drive(1'($urandom), rnd_sample(), rnd_sample());
         else drive(1'b0, 0, 0);
         tick();
         cyc++;
      end
      drive(1'b0, 0, 0);
      check("done_latency", cyc, lg * nn / 2 + 1);
      check("busy_cycles", bcnt, lg * nn / 2);
      for (int i = 0; i < nn; i++) begin
         set_s(i);
         tick();
         got_re[i] = y_re_now();
         got_im[i] = y_im_now();
         check("bin_re", got_re[i], ex_re[i]);
         check("bin_im", got_im[i], ex_im[i]);
      end
   endtask

   task automatic run_frame(input bit gap, input bit pulse);
      model();
      load_frame(gap);
      finish_frame(pulse);
   endtask

   task automatic async_reset(input string tag);
      #2;
      r = 1'b1;
      #1;
      check({tag, "_busy"}, busy_now(), 0);
      check({tag, "_done"}, done_now(), 0);
      check({tag, "_yre"}, y_re_now(), 0);
      check({tag, "_yim"}, y_im_now(), 0);
      @(posedge c);
      #1;
      r = 1'b0;
   endtask

   task automatic set_frame(input int kind);
      for (int k = 0; k < 16; k++) begin
         fr_im[k] = 0;
         case (kind)
            0: fr_re[k] = (k == 0) ? 1 : 0;
            1: fr_re[k] = (k % 2 == 0) ? 1 : 0;
            2: fr_re[k] = (k == 0 || k == 7) ? 1 : 0;
            3: fr_re[k] = 1;
            4: fr_re[k] = -1;
            default: begin
               fr_re[k] = rnd_sample();
               fr_im[k] = rnd_sample();
            end
         endcase
      end
   endtask

   initial begin
      r = 1'b1;
      e_a = 1'b0; xr_a = '0; xi_a = '0; s_a = '0;
      e_b = 1'b0; xr_b = '0; xi_b = '0; s_b = '0;
      use_dut(0);
      repeat (3) @(posedge c);
      #1;
      check("rst_busy", busy_now(), 0);
      check("rst_done", done_now(), 0);
      check("rst_yre", y_re_now(), 0);
      check("rst_yim", y_im_now(), 0);
      r = 1'b0;

      set_frame(0);
      run_frame(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         check("impulse_re", got_re[i], 1);
         check("impulse_im", got_im[i], 0);
      end

      set_frame(1);
      run_frame(1'b0, 1'b0);
      check("alt_bin0", got_re[0], 4);
      check("alt_bin4", got_re[4], 4);
      check("alt_bin2", got_re[2], 0);

      set_frame(2);
      run_frame(1'b0, 1'b0);
      check("ends_bin0_re", got_re[0], 2);
      check("ends_bin4_re", got_re[4], 0);
      check("ends_bin2_re", got_re[2], 1);
      check("ends_bin2_im", got_im[2], 1);
      check("ends_bin6_re", got_re[6], 1);
      check("ends_bin6_im", got_im[6], -1);

      set_frame(0);
      run_frame(1'b1, 1'b1);
      for (int i = 0; i < 8; i++) check("gapped_re", got_re[i], 1);

      // Abort in stage 1 of the transform.
      set_frame(5);
      load_frame(1'b0);
      repeat (6) tick();
      async_reset("rst_comp");

      set_frame(3);
      run_frame(1'b0, 1'b0);
      check("ones_bin0", got_re[0], 8);
      for (int i = 1; i < 8; i++) check("ones_other", got_re[i], 0);
      set_s(0);
      tick();
      check("ones_read", y_re_now(), 8);
      async_reset("rst_done");

      // Partial frame must be discarded.
      set_frame(5);
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1, 1);
         tick();
      end
      drive(1'b0, 0, 0);
      async_reset("rst_load");

      for (int f = 0; f < 3; f++) begin
         set_frame(5);
         run_frame(f[0], f[1]);
      end

      use_dut(1);
      set_frame(4);
      run_frame(1'b0, 1'b0);
      check("neg_bin0", got_re[0], -16);
      for (int i = 1; i < 16; i++) check("neg_other", got_re[i], 0);
      for (int f = 0; f < 2; f++) begin
         set_frame(5);
         run_frame(f[0], 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
